// File: rtl/uart_pkg.sv
// Shared constants for the UART receive FIFO slice: default character width,
// default queue depth and the width of the optional dropped-character counter
// (present only when UART_RXFIFO_DROPCNT_EN is defined).
package uart_pkg;

  localparam int unsigned WDATA_DEF = 8;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned DROPCNT_W = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: Depth x Wdata entries with a
// synchronous write port and an asynchronous (combinational) read port, so
// the head entry is visible on the read data the moment it is addressed.
// Contents are deliberately not reset; validity is tracked by the caller.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int Wdata = WDATA_DEF,
  parameter int Depth = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Wdata-1:0]         i_wdata,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Wdata-1:0]         o_rdata
);

  logic [Wdata-1:0] r_mem [Depth];

  // Write the incoming character into the addressed slot.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO behind a UART receiver.
// Characters arrive as single-cycle INT strobes with DIN; the consumer sees
// the head on DOUT whenever VALID is high. A character that arrives while the
// queue is full (and nothing leaves that cycle) is dropped and OVF is set.
// Optional feature macro: UART_RXFIFO_DROPCNT_EN adds an 8-bit saturating
// DROPS counter of dropped characters, cleared by OVF_CLR and by reset.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int Wdata = WDATA_DEF,
  parameter int Depth = DEPTH_DEF
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [Wdata-1:0]       DIN,
  input  logic                   INT,
  output logic [Wdata-1:0]       DOUT,
  output logic                   VALID,
  input  logic                   READY,
  output logic [$clog2(Depth):0] LEVEL,
  output logic                   OVF,
  input  logic                   OVF_CLR
`ifdef UART_RXFIFO_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0]   DROPS
`endif
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(Depth);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic [Wdata-1:0] w_rd_data;
  logic             w_full;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Handshake: VALID means the queue holds at least one character and DOUT is
  // its head; a pop happens on any rising edge where VALID and READY are both
  // high, and READY while VALID is low is ignored. INT is a push request with
  // no back-pressure: it is accepted when there is room, or when the queue is
  // full but a pop frees a slot on the same edge, otherwise the character is
  // dropped.
  assign w_full  = (r_level == FULL_LEVEL);
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid & READY;
  assign w_push  = INT & (~w_full | w_pop);
  assign w_drop  = INT & w_full & ~w_pop;

  uart_fifo_mem #(
    .Wdata (Wdata),
    .Depth (Depth)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (DIN),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Pointers advance by one per accepted push/pop; Depth is a power of two so
  // they wrap naturally with no gaps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: up on push-only, down on pop-only, unchanged otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as OVF_CLR keeps it set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (OVF_CLR) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef UART_RXFIFO_DROPCNT_EN
  logic [DROPCNT_W-1:0] r_drops;

  // Saturating dropped-character count; a drop coinciding with OVF_CLR starts
  // the fresh count at one so that drop is not lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_drops <= '0;
    end else if (OVF_CLR) begin
      r_drops <= w_drop ? DROPCNT_W'(1) : '0;
    end else if (w_drop && (r_drops != '1)) begin
      r_drops <= r_drops + DROPCNT_W'(1);
    end
  end

  assign DROPS = r_drops;
`endif

  // Empty queue (including during reset) presents all-zero on DOUT.
  assign DOUT  = w_valid ? w_rd_data : '0;
  assign VALID = w_valid;
  assign LEVEL = r_level;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios followed by random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_uart_rx_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          int_strb;
  logic [W-1:0]  dout;
  logic          valid;
  logic          ready;
  logic [LW-1:0] level;
  logic          ovf;
  logic          ovf_clr;
`ifdef UART_RXFIFO_DROPCNT_EN
  logic [7:0]    drops;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .Wdata (W),
    .Depth (DEPTH)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .DIN     (din),
    .INT     (int_strb),
    .DOUT    (dout),
    .VALID   (valid),
    .READY   (ready),
    .LEVEL   (level),
    .OVF     (ovf),
    .OVF_CLR (ovf_clr)
`ifdef UART_RXFIFO_DROPCNT_EN
    ,
    .DROPS   (drops)
`endif
  );

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  int           m_level = 0;
  logic         m_ovf = 1'b0;
  int           m_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of characters plus an overflow flag.
  always @(posedge clk or negedge rst_n) begin : model
    bit pop;
    bit drop;
    if (!rst_n) begin
      m_level = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
      exp_q.delete();
    end else begin
      pop  = (m_level > 0) && (ready === 1'b1);
      drop = 1'b0;
      if (int_strb === 1'b1) begin
        if (m_level < DEPTH || pop) begin
          exp_q.push_back(din);
          m_level++;
        end else begin
          drop = 1'b1;
        end
      end
      if (pop) m_level--;
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr === 1'b1) m_ovf = 1'b0;
      if (ovf_clr === 1'b1) m_drops = drop ? 1 : 0;
      else if (drop && m_drops < 255) m_drops++;
    end
  end

  // Monitor: compare status every cycle; compare and retire the head on pops.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("level", 32'(level), 32'(m_level));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("valid", 32'(valid), 32'(m_level > 0));
`ifdef UART_RXFIFO_DROPCNT_EN
      check("drops", 32'(drops), 32'(m_drops));
`endif
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dout: VALID high with DOUT=0x%0h but no character expected at t=%0t", dout, $time);
        end else begin
          check("dout", 32'(dout), 32'(exp_q[0]));
          if (ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit i, input logic [W-1:0] d, input bit r, input bit c);
    int_strb = i;
    din      = d;
    ready    = r;
    ovf_clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) cycle(1'b1, base + W'(i), 1'b0, 1'b0);
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge.
  task automatic async_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_ovf"},   32'(ovf),   32'd0);
    check({tag, "_dout"},  32'(dout),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b1;
    din      = '0;
    int_strb = 1'b0;
    ready    = 1'b0;
    ovf_clr  = 1'b0;
    @(posedge clk);
    async_reset("reset");
    idle(2);

    // Single character in and out.
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    idle(1);
    drain(1);
    idle(2);

    // Fill to full, overflow with 0xAA, drain in order, clear OVF.
    fill(DEPTH, 8'h00);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(1);
    drain(DEPTH);
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // Full queue: push 0x55 together with a pop.
    fill(DEPTH, 8'h80);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    idle(1);
    drain(DEPTH);
    idle(1);

    // Streaming push and pop every cycle across pointer wrap.
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'h10 + W'(i), 1'b1, 1'b0);
    drain(2);
    idle(1);

    // Overflow coinciding with OVF_CLR keeps OVF; OVF_CLR alone clears it.
    fill(DEPTH, 8'hC0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    drain(DEPTH);
    idle(1);

    // Reset with five queued characters, then a fresh character.
    fill(5, 8'h30);
    idle(1);
    async_reset("midreset");
    cycle(1'b1, 8'h7E, 1'b0, 1'b0);
    idle(1);
    drain(1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, W'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4);
    end
    drain(DEPTH + 4);
    idle(2);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
